// File: rtl/ysyx_210544_csr_file_pkg.sv
// Shared CSR addresses, mstatus field positions and masks, and the ecall cause code.
// The CSR file top lists its build-time option in its own file header.
package ysyx_210544_csr_file_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_FS_LO  = 13;
  localparam int MSTATUS_SD     = 63;

  localparam logic [63:0] MSTATUS_WMASK  = 64'h0000_0000_0000_7888;
  localparam logic [63:0] MSTATUS_RESET  = 64'h0000_0000_0000_1800;
  localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;

  // SD is not stored; it summarises a dirty FS field.
  function automatic logic [63:0] mstatus_view(input logic [63:0] stored);
    logic [63:0] v;
    v = stored & MSTATUS_WMASK;
    v[MSTATUS_SD] = &stored[MSTATUS_FS_LO +: 2];
    return v;
  endfunction

endpackage

// File: rtl/ysyx_210544_csr_counter.sv
// 64-bit free-running CSR counter with a software load that takes priority
// over the same-cycle increment; wraps naturally at 2^64.
module ysyx_210544_csr_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_val,
  input  logic        inc,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 64'd0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_210544_csr_file.sv
// Machine-mode CSR file with ecall/mret trap handling and mcycle/minstret counters.
// Build option: YSYX_210544_CSR_MINSTRET_EN enables the minstret counter.
module ysyx_210544_csr_file
  import ysyx_210544_csr_file_pkg::*;
#(
  parameter logic [63:0] HARTID = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] i_csr_addr,
  input  logic        i_csr_ren,
  input  logic        i_csr_wen,
  input  logic [63:0] i_csr_wdata,
  output logic [63:0] o_csr_rdata,
  input  logic        i_instr_retire,
  input  logic        i_ecall,
  input  logic        i_mret,
  input  logic [63:0] i_epc,
  output logic        o_trap_jmp,
  output logic [63:0] o_trap_addr
);

  logic [63:0] mstatus;
  logic [63:0] mie;
  logic [63:0] mtvec;
  logic [63:0] mscratch;
  logic [63:0] mepc;
  logic [63:0] mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic        wr_en;

  // A trap in the same cycle drops the software write entirely.
  assign wr_en = i_csr_wen & ~i_ecall & ~i_mret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus  <= MSTATUS_RESET;
      mie      <= 64'd0;
      mtvec    <= 64'd0;
      mscratch <= 64'd0;
      mepc     <= 64'd0;
      mcause   <= 64'd0;
    end else if (i_ecall) begin
      mepc                           <= i_epc & ~64'd1;
      mcause                         <= MCAUSE_ECALL_M;
      mstatus[MSTATUS_MPIE]          <= mstatus[MSTATUS_MIE];
      mstatus[MSTATUS_MIE]           <= 1'b0;
      mstatus[MSTATUS_MPP_LO +: 2]   <= 2'b11;
    end else if (i_mret) begin
      mstatus[MSTATUS_MIE]           <= mstatus[MSTATUS_MPIE];
      mstatus[MSTATUS_MPIE]          <= 1'b1;
      mstatus[MSTATUS_MPP_LO +: 2]   <= 2'b11;
    end else if (wr_en) begin
      case (i_csr_addr)
        CSR_MSTATUS:  mstatus  <= i_csr_wdata & MSTATUS_WMASK;
        CSR_MIE:      mie      <= i_csr_wdata;
        CSR_MTVEC:    mtvec    <= i_csr_wdata;
        CSR_MSCRATCH: mscratch <= i_csr_wdata;
        CSR_MEPC:     mepc     <= i_csr_wdata & ~64'd1;
        CSR_MCAUSE:   mcause   <= i_csr_wdata;
        default:      ;
      endcase
    end
  end

  ysyx_210544_csr_counter u_mcycle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wr_en && (i_csr_addr == CSR_MCYCLE)),
    .load_val (i_csr_wdata),
    .inc      (1'b1),
    .count    (mcycle)
  );

`ifdef YSYX_210544_CSR_MINSTRET_EN
  ysyx_210544_csr_counter u_minstret (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wr_en && (i_csr_addr == CSR_MINSTRET)),
    .load_val (i_csr_wdata),
    .inc      (i_instr_retire),
    .count    (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = i_instr_retire;
  assign minstret      = 64'd0;
`endif

  always_comb begin
    o_csr_rdata = 64'd0;
    if (i_csr_ren) begin
      case (i_csr_addr)
        CSR_MSTATUS:  o_csr_rdata = mstatus_view(mstatus);
        CSR_MIE:      o_csr_rdata = mie;
        CSR_MTVEC:    o_csr_rdata = mtvec;
        CSR_MSCRATCH: o_csr_rdata = mscratch;
        CSR_MEPC:     o_csr_rdata = mepc;
        CSR_MCAUSE:   o_csr_rdata = mcause;
        CSR_MIP:      o_csr_rdata = 64'd0;
        CSR_MCYCLE:   o_csr_rdata = mcycle;
        CSR_MINSTRET: o_csr_rdata = minstret;
        CSR_MHARTID:  o_csr_rdata = HARTID;
        default:      o_csr_rdata = 64'd0;
      endcase
    end
  end

  always_comb begin
    o_trap_jmp  = 1'b0;
    o_trap_addr = 64'd0;
    if (i_ecall) begin
      o_trap_jmp  = 1'b1;
      o_trap_addr = {mtvec[63:2], 2'b00};
    end else if (i_mret) begin
      o_trap_jmp  = 1'b1;
      o_trap_addr = mepc;
    end
  end

endmodule

// File: tb/tb_ysyx_210544_csr_file.sv
// Directed bench for the CSR file: reset, traps, counters, priority, masking.
module tb_ysyx_210544_csr_file;

  localparam logic [63:0] TB_HARTID = 64'h0000_0000_0000_005A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] i_csr_addr = 12'h0;
  logic        i_csr_ren = 1'b0;
  logic        i_csr_wen = 1'b0;
  logic [63:0] i_csr_wdata = 64'd0;
  logic [63:0] o_csr_rdata;
  logic        i_instr_retire = 1'b0;
  logic        i_ecall = 1'b0;
  logic        i_mret = 1'b0;
  logic [63:0] i_epc = 64'd0;
  logic        o_trap_jmp;
  logic [63:0] o_trap_addr;

  int checks = 0;
  int failures = 0;

  ysyx_210544_csr_file #(.HARTID(TB_HARTID)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_csr_addr     (i_csr_addr),
    .i_csr_ren      (i_csr_ren),
    .i_csr_wen      (i_csr_wen),
    .i_csr_wdata    (i_csr_wdata),
    .o_csr_rdata    (o_csr_rdata),
    .i_instr_retire (i_instr_retire),
    .i_ecall        (i_ecall),
    .i_mret         (i_mret),
    .i_epc          (i_epc),
    .o_trap_jmp     (o_trap_jmp),
    .o_trap_addr    (o_trap_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [63:0] d);
    i_csr_addr = a;
    i_csr_ren  = 1'b1;
    #1;
    d = o_csr_rdata;
    i_csr_ren  = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] v);
    i_csr_addr  = a;
    i_csr_wdata = v;
    i_csr_wen   = 1'b1;
    tick();
    i_csr_wen   = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] d;
    rst_n = 1'b0;
    repeat (3) tick();
    rd(12'h300, d);
    checks++;
    if (d !== 64'h1800) begin failures++; $display("FAIL reset_mstatus_held got=%h exp=%h", d, 64'h1800); end
    rd(12'hB00, d);
    checks++;
    if (d !== 64'd0) begin failures++; $display("FAIL reset_mcycle_held got=%h exp=0", d); end
    rst_n = 1'b1;
    rd(12'h300, d);
    checks++;
    if (d !== 64'h1800) begin failures++; $display("FAIL release_mstatus got=%h exp=%h", d, 64'h1800); end
    tick();
    tick();
    rd(12'hB00, d);
    checks++;
    if (d !== 64'd2) begin failures++; $display("FAIL release_mcycle got=%h exp=2", d); end
  endtask

  task automatic test_ecall();
    logic [63:0] d;
    wr(12'h305, 64'h8000_0103);
    i_ecall = 1'b1;
    i_epc   = 64'h8000_0010;
    #1;
    checks++;
    if (o_trap_jmp !== 1'b1) begin failures++; $display("FAIL ecall_jmp got=%b exp=1", o_trap_jmp); end
    checks++;
    if (o_trap_addr !== 64'h8000_0100) begin failures++; $display("FAIL ecall_addr got=%h exp=%h", o_trap_addr, 64'h8000_0100); end
    tick();
    i_ecall = 1'b0;
    rd(12'h341, d);
    checks++;
    if (d !== 64'h8000_0010) begin failures++; $display("FAIL ecall_mepc got=%h exp=%h", d, 64'h8000_0010); end
    rd(12'h342, d);
    checks++;
    if (d !== 64'd11) begin failures++; $display("FAIL ecall_mcause got=%h exp=11", d); end
    rd(12'h300, d);
    checks++;
    if (d !== 64'h1800) begin failures++; $display("FAIL ecall_mstatus got=%h exp=%h", d, 64'h1800); end
  endtask

  task automatic test_mret();
    logic [63:0] d;
    wr(12'h300, 64'h8);
    i_ecall = 1'b1;
    i_epc   = 64'h8000_0021;
    tick();
    i_ecall = 1'b0;
    rd(12'h300, d);
    checks++;
    if (d !== 64'h1880) begin failures++; $display("FAIL mret_pre_mstatus got=%h exp=%h", d, 64'h1880); end
    rd(12'h341, d);
    checks++;
    if (d !== 64'h8000_0020) begin failures++; $display("FAIL mret_mepc_bit0 got=%h exp=%h", d, 64'h8000_0020); end
    i_mret = 1'b1;
    #1;
    checks++;
    if (o_trap_jmp !== 1'b1 || o_trap_addr !== 64'h8000_0020) begin
      failures++; $display("FAIL mret_target got=%b/%h exp=1/%h", o_trap_jmp, o_trap_addr, 64'h8000_0020);
    end
    tick();
    i_mret = 1'b0;
    rd(12'h300, d);
    checks++;
    if (d !== 64'h1888) begin failures++; $display("FAIL mret_mstatus got=%h exp=%h", d, 64'h1888); end
    checks++;
    if (o_trap_jmp !== 1'b0 || o_trap_addr !== 64'd0) begin
      failures++; $display("FAIL trap_idle got=%b/%h exp=0/0", o_trap_jmp, o_trap_addr);
    end
  endtask

  task automatic test_mcycle_wrap();
    logic [63:0] d;
    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'hB00, d);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL mcycle_load got=%h exp=all-ones", d); end
    tick();
    rd(12'hB00, d);
    checks++;
    if (d !== 64'd0) begin failures++; $display("FAIL mcycle_wrap got=%h exp=0", d); end
  endtask

  task automatic test_priority();
    logic [63:0] d;
    wr(12'h340, 64'h1234);
    i_ecall     = 1'b1;
    i_epc       = 64'h40;
    i_csr_addr  = 12'h340;
    i_csr_wdata = 64'd5;
    i_csr_wen   = 1'b1;
    tick();
    i_ecall   = 1'b0;
    i_csr_wen = 1'b0;
    rd(12'h340, d);
    checks++;
    if (d !== 64'h1234) begin failures++; $display("FAIL ecall_over_wen got=%h exp=%h", d, 64'h1234); end
    rd(12'h341, d);
    checks++;
    if (d !== 64'h40) begin failures++; $display("FAIL ecall_over_wen_mepc got=%h exp=%h", d, 64'h40); end
    i_mret      = 1'b1;
    i_csr_addr  = 12'h305;
    i_csr_wdata = 64'h55;
    i_csr_wen   = 1'b1;
    tick();
    i_mret    = 1'b0;
    i_csr_wen = 1'b0;
    rd(12'h305, d);
    checks++;
    if (d !== 64'h8000_0103) begin failures++; $display("FAIL mret_over_wen got=%h exp=%h", d, 64'h8000_0103); end
    i_ecall = 1'b1;
    i_mret  = 1'b1;
    #1;
    checks++;
    if (o_trap_addr !== 64'h8000_0100) begin failures++; $display("FAIL ecall_over_mret got=%h exp=%h", o_trap_addr, 64'h8000_0100); end
    i_ecall = 1'b0;
    i_mret  = 1'b0;
    tick();
  endtask

  task automatic test_readonly();
    logic [63:0] d;
    wr(12'hF14, 64'hDEAD);
    rd(12'hF14, d);
    checks++;
    if (d !== TB_HARTID) begin failures++; $display("FAIL hartid got=%h exp=%h", d, TB_HARTID); end
    wr(12'h344, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h344, d);
    checks++;
    if (d !== 64'd0) begin failures++; $display("FAIL mip_ignored got=%h exp=0", d); end
    wr(12'h123, 64'h77);
    rd(12'h123, d);
    checks++;
    if (d !== 64'd0) begin failures++; $display("FAIL unimpl_read got=%h exp=0", d); end
    i_csr_addr = 12'h305;
    i_csr_ren  = 1'b0;
    #1;
    checks++;
    if (o_csr_rdata !== 64'd0) begin failures++; $display("FAIL no_ren_zero got=%h exp=0", o_csr_rdata); end
    wr(12'h304, 64'hA5A5);
    rd(12'h304, d);
    checks++;
    if (d !== 64'hA5A5) begin failures++; $display("FAIL mie_rw got=%h exp=%h", d, 64'hA5A5); end
  endtask

  task automatic test_mstatus_mask();
    logic [63:0] d;
    wr(12'h300, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(12'h300, d);
    checks++;
    if (d !== 64'h8000_0000_0000_7888) begin failures++; $display("FAIL mstatus_mask_sd got=%h exp=%h", d, 64'h8000_0000_0000_7888); end
    wr(12'h300, 64'h2000);
    rd(12'h300, d);
    checks++;
    if (d !== 64'h2000) begin failures++; $display("FAIL mstatus_fs_nosd got=%h exp=%h", d, 64'h2000); end
  endtask

  task automatic test_async_reset();
    logic [63:0] d;
    i_csr_addr  = 12'h340;
    i_csr_wdata = 64'h99;
    i_csr_wen   = 1'b1;
    rst_n       = 1'b0;
    rd(12'h305, d);
    checks++;
    if (d !== 64'd0) begin failures++; $display("FAIL async_reset_mtvec got=%h exp=0", d); end
    tick();
    i_csr_wen = 1'b0;
    rst_n     = 1'b1;
    tick();
    rd(12'h340, d);
    checks++;
    if (d !== 64'd0) begin failures++; $display("FAIL reset_drops_write got=%h exp=0", d); end
    rd(12'h300, d);
    checks++;
    if (d !== 64'h1800) begin failures++; $display("FAIL async_reset_mstatus got=%h exp=%h", d, 64'h1800); end
  endtask

  task automatic test_minstret();
    logic [63:0] d;
    logic [63:0] exp3;
    logic [63:0] exp100;
`ifdef YSYX_210544_CSR_MINSTRET_EN
    exp3   = 64'd3;
    exp100 = 64'd100;
`else
    exp3   = 64'd0;
    exp100 = 64'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      i_instr_retire = 1'b1;
      tick();
      i_instr_retire = 1'b0;
      tick();
    end
    rd(12'hB02, d);
    checks++;
    if (d !== exp3) begin failures++; $display("FAIL minstret_count got=%h exp=%h", d, exp3); end
    i_instr_retire = 1'b1;
    wr(12'hB02, 64'd100);
    i_instr_retire = 1'b0;
    rd(12'hB02, d);
    checks++;
    if (d !== exp100) begin failures++; $display("FAIL minstret_write_wins got=%h exp=%h", d, exp100); end
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_mret();
    test_mcycle_wrap();
    test_priority();
    test_readonly();
    test_mstatus_mask();
    test_async_reset();
    test_minstret();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_210544_csr_file.md
YSYX_210544_CSR_FILE -- requirements
Module: ysyx_210544_csr_file

Interface
REQ-001 SHALL have parameter: HARTID, 0, value returned by mhartid (0xF14).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_csr_addr  input  12  CSR address from execute unit.
REQ-005 SHALL have port: i_csr_ren  input  1  read strobe.
REQ-006 SHALL have port: i_csr_wen  input  1  write strobe.
REQ-007 SHALL have port: i_csr_wdata  input  64  write value, already merged (RW/RS/RC) by execute unit.
REQ-008 SHALL have port: o_csr_rdata  output  64  read value.
REQ-009 SHALL have port: i_instr_retire  input  1  one instruction committed this cycle.
REQ-010 SHALL have port: i_ecall  input  1  environment-call trap request.
REQ-011 SHALL have port: i_mret  input  1  trap-return request.
REQ-012 SHALL have port: i_epc  input  64  PC of trapping instruction.
REQ-013 SHALL have port: o_trap_jmp  output  1  redirect fetch this cycle.
REQ-014 SHALL have port: o_trap_addr  output  64  redirect target.

Function
REQ-015 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle 0xB00, minstret 0xB02, mhartid 0xF14.
REQ-016 SHALL drive o_csr_rdata combinationally, same cycle: current register value when i_csr_ren=1, else 0; unimplemented address reads 0.
REQ-017 SHALL commit a write at the rising edge after i_csr_wen=1 (latency 1); writes to unimplemented addresses, mhartid, and mip are ignored.
REQ-018 SHALL store on mstatus write only bits MIE[3], MPIE[7], MPP[12:11], FS[14:13]; bit 63 (SD) SHALL read as (FS==2'b11); all other bits read 0.
REQ-019 SHALL store mepc with bit 0 forced 0; mtvec SHALL store all 64 bits.
REQ-020 SHALL increment mcycle by 1 every cycle out of reset, wrapping 2^64-1 -> 0.
REQ-021 SHALL on a cycle with i_csr_wen to mcycle load i_csr_wdata and suppress that cycle's increment (write wins).
REQ-022 SHALL on i_ecall: mepc<=i_epc&~1, mcause<=64'd11, MPIE<=MIE, MIE<=0, MPP<=2'b11; o_trap_jmp=1, o_trap_addr={mtvec[63:2],2'b00} same cycle.
REQ-023 SHALL on i_mret: MIE<=MPIE, MPIE<=1, MPP<=2'b11; o_trap_jmp=1, o_trap_addr=mepc same cycle.
REQ-024 SHALL prioritise simultaneous events: i_ecall > i_mret > i_csr_wen; lower-priority register updates that cycle SHALL be dropped.
REQ-025 SHALL hold o_trap_jmp=0 and o_trap_addr=0 when neither i_ecall nor i_mret is asserted.

Reset
REQ-026 SHALL on rst_n low, immediately and regardless of clk, set mstatus=64'h1800, mcycle, minstret, mie, mtvec, mscratch, mepc, mcause to 0.
REQ-027 SHALL keep outputs combinationally derived from reset register values while rst_n low; reset mid-write discards the pending write.

Configuration
REQ-028 SHALL compile minstret only when YSYX_210544_CSR_MINSTRET_EN is defined: increments by 1 on each edge with i_instr_retire=1, wraps at 2^64, write to 0xB02 wins over same-cycle increment.
REQ-029 SHALL without YSYX_210544_CSR_MINSTRET_EN read 0xB02 as 0, ignore writes, ignore i_instr_retire.

Structure
REQ-030 SHALL take CSR address constants, mstatus bit-position constants, mstatus write mask and mcause code 11 from the shared defines file.
REQ-031 SHALL place both 64-bit counters in one sub-module ysyx_210544_csr_counter (load, increment enable, wrap), instantiated for mcycle and minstret.

Verification
REQ-032 SHALL verify: reset release, read 0x300 -> 64'h1800; read 0xB00 two cycles later -> 2.
REQ-033 SHALL verify: write mtvec=64'h8000_0103, then i_ecall with i_epc=64'h8000_0010 -> o_trap_addr=64'h8000_0100, next cycle mepc=64'h8000_0010, mcause=11, MIE=0.
REQ-034 SHALL verify: mstatus write 64'h8 then ecall then mret -> MIE=1, MPIE=1, o_trap_addr=mepc.
REQ-035 SHALL verify: mcycle write 64'hFFFF_FFFF_FFFF_FFFF -> reads that value next cycle, 0 the cycle after.
REQ-036 SHALL verify: i_ecall with i_csr_wen to mscratch=5 same cycle -> mscratch unchanged; write 0xF14 -> read HARTID.
REQ-037 SHALL verify: with YSYX_210544_CSR_MINSTRET_EN, 3 retire pulses -> 0xB02 reads 3; without it -> 0.
